// File: rtl/spectrum_capture.sv
// spectrum_capture
//   Collects one FFT magnitude frame into a shadow buffer, waits for a video
//   frame tick, then copies the shadow into the display spectrum one bin per
//   cycle. The copy is either plain or peak-hold with exponential decay.
//
// Ports
//   Clk           sole clock, everything updates on posedge Clk
//   Reset         synchronous, active-high
//   frame_clk     video frame tick (level), rising edge detected in Clk domain
//   mag_data      FFT magnitude for the current bin
//   mag_valid     mag_data is valid
//   mag_last      final beat of an FFT frame
//   mag_ready     block accepts a beat (high in FILL and DRAIN)
//   audio_output  display spectrum, bin i at [i*WIDTH +: WIDTH]
//   commit_done   one-cycle pulse after the last bin has been committed
//   overrun       sticky: a frame carried more than BINS beats
//   short_frame   sticky: mag_last came before BINS beats
//   state_dbg     current FSM state (FILL=0, DRAIN=1, WAIT_TICK=2, COMMIT=3)
//
// Handshake: a beat transfers in exactly the cycles where mag_valid and
// mag_ready are both high at the rising edge of Clk. mag_ready depends only on
// the registered state, never on mag_valid, so a source may hold a beat for
// any number of cycles without it being consumed.
module spectrum_capture #(
  parameter int BINS        = 256,
  parameter int WIDTH       = 32,
  parameter int DECAY_SHIFT = 3,
  parameter int PEAK_HOLD   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [WIDTH-1:0]        mag_data,
  input  logic                    mag_valid,
  input  logic                    mag_last,
  output logic                    mag_ready,
  output logic [BINS*WIDTH-1:0]   audio_output,
  output logic                    commit_done,
  output logic                    overrun,
  output logic                    short_frame,
  output logic [1:0]              state_dbg
);

  localparam int IDX_W = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    DRAIN     = 2'd1,
    WAIT_TICK = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             frame_clk_q;
  logic             accept;
  logic             tick;

  logic [WIDTH-1:0] shadow [BINS];
  logic [WIDTH-1:0] out_r  [BINS];

  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] sh_bin;
  logic [WIDTH-1:0] decayed;
  logic [WIDTH-1:0] commit_val;

  assign mag_ready = (state == FILL) || (state == DRAIN);
  assign accept    = mag_valid && mag_ready;
  assign tick      = frame_clk && !frame_clk_q;
  assign state_dbg = state;

  // Decayed value never underflows: the shifted term is at most cur_bin.
  always_comb begin
    cur_bin    = out_r[rd_idx];
    sh_bin     = shadow[rd_idx];
    decayed    = cur_bin - (cur_bin >> DECAY_SHIFT);
    commit_val = sh_bin;
    if (PEAK_HOLD != 0 && decayed > sh_bin) begin
      commit_val = decayed;
    end
  end

  // Shadow has no reset; the first full frame after reset defines every bin.
  always_ff @(posedge Clk) begin
    if (!Reset && state == FILL && accept) begin
      shadow[wr_idx] <= mag_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      frame_clk_q <= 1'b0;
      commit_done <= 1'b0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
      for (int i = 0; i < BINS; i++) begin
        out_r[i] <= '0;
      end
    end else begin
      frame_clk_q <= frame_clk;
      commit_done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (mag_last) begin
              if (wr_idx != LAST_IDX) begin
                short_frame <= 1'b1;
              end
              state  <= WAIT_TICK;
              wr_idx <= '0;
            end else if (wr_idx == LAST_IDX) begin
              // Frame is full but not terminated: keep it, discard the rest.
              overrun <= 1'b1;
              state   <= DRAIN;
              wr_idx  <= '0;
            end
          end
        end
        DRAIN: begin
          if (accept && mag_last) begin
            state <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            state  <= COMMIT;
            rd_idx <= '0;
          end
        end
        COMMIT: begin
          out_r[rd_idx] <= commit_val;
          if (rd_idx == LAST_IDX) begin
            commit_done <= 1'b1;
            state       <= FILL;
            rd_idx      <= '0;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar g = 0; g < BINS; g++) begin : g_out
    assign audio_output[g*WIDTH +: WIDTH] = out_r[g];
  end

endmodule

// File: tb/tb_spectrum_capture.sv
// Bench for spectrum_capture. Two instances share all inputs: one plain copy
// (PEAK_HOLD=0) and one peak-hold (PEAK_HOLD=1, DECAY_SHIFT=3). A frame-level
// model tracks the shadow buffer, the two displayed spectra and the flags.
module tb_spectrum_capture;
  localparam int BINS  = 256;
  localparam int WIDTH = 32;
  localparam int DS    = 3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  logic [WIDTH-1:0] mag_data = '0;
  logic mag_valid = 1'b0;
  logic mag_last = 1'b0;

  logic rdy_c, rdy_p, done_c, done_p, ovr_c, ovr_p, sh_c, sh_p;
  logic [BINS*WIDTH-1:0] out_c, out_p;
  logic [1:0] st_c, st_p;

  always #5 Clk = ~Clk;

  spectrum_capture #(.BINS(BINS), .WIDTH(WIDTH), .DECAY_SHIFT(DS), .PEAK_HOLD(0)) u_copy (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .mag_data(mag_data),
    .mag_valid(mag_valid), .mag_last(mag_last), .mag_ready(rdy_c),
    .audio_output(out_c), .commit_done(done_c), .overrun(ovr_c),
    .short_frame(sh_c), .state_dbg(st_c)
  );

  spectrum_capture #(.BINS(BINS), .WIDTH(WIDTH), .DECAY_SHIFT(DS), .PEAK_HOLD(1)) u_peak (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .mag_data(mag_data),
    .mag_valid(mag_valid), .mag_last(mag_last), .mag_ready(rdy_p),
    .audio_output(out_p), .commit_done(done_p), .overrun(ovr_p),
    .short_frame(sh_p), .state_dbg(st_p)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] beat_data [400];
  logic [WIDTH-1:0] m_shadow [BINS];
  logic [WIDTH-1:0] m_copy   [BINS];
  logic [WIDTH-1:0] m_peak   [BINS];
  bit m_short, m_over;

  typedef struct {
    int n_beats;
    bit reset_first;
    bit exp_short;
    bit exp_over;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic void model_frame(input int n);
    for (int i = 0; i < BINS && i < n; i++) m_shadow[i] = beat_data[i];
    if (n < BINS) m_short = 1'b1;
    if (n > BINS) m_over = 1'b1;
  endfunction

  function automatic void model_commit();
    longint unsigned d;
    for (int i = 0; i < BINS; i++) begin
      m_copy[i] = m_shadow[i];
      d = longint'(m_peak[i]) - longint'(m_peak[i]) / (1 << DS);
      m_peak[i] = (longint'(m_shadow[i]) > d) ? m_shadow[i] : WIDTH'(d);
    end
  endfunction

  task automatic compare_vec(input string tag, input logic [BINS*WIDTH-1:0] act,
                             input logic [WIDTH-1:0] mdl [BINS]);
    int bad, first;
    logic [WIDTH-1:0] e, g, fe, fg;
    bad = 0; first = -1; fe = '0; fg = '0;
    exp_q.delete();
    for (int i = 0; i < BINS; i++) exp_q.push_back(mdl[i]);
    for (int i = 0; i < BINS; i++) begin
      e = exp_q.pop_front();
      g = act[i*WIDTH +: WIDTH];
      if (g !== e) begin
        bad++;
        if (first < 0) begin first = i; fe = e; fg = g; end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bins differ, bin %0d got %0d expected %0d", tag, bad, first, fg, fe);
    end
  endtask

  task automatic compare_all(input string tag);
    compare_vec({tag, "_copy"}, out_c, m_copy);
    compare_vec({tag, "_peak"}, out_p, m_peak);
    check({tag, "_short"}, {sh_c, sh_p}, {m_short, m_short});
    check({tag, "_overrun"}, {ovr_c, ovr_p}, {m_over, m_over});
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    Reset = 1'b1; mag_valid = 1'b0; mag_last = 1'b0; frame_clk = 1'b0;
    step();
    Reset = 1'b0;
    for (int i = 0; i < BINS; i++) begin m_copy[i] = '0; m_peak[i] = '0; end
    m_short = 1'b0; m_over = 1'b0;
  endtask

  // Streams beats first..n-1 from beat_data, mag_last on the final one.
  task automatic drive_beats(input int first, input int n);
    bit acc;
    int guard;
    for (int i = first; i < n; i++) begin
      mag_valid = 1'b1;
      mag_data  = beat_data[i];
      mag_last  = (i == n - 1);
      acc = 1'b0; guard = 0;
      while (!acc && guard < 2000) begin
        acc = rdy_p;
        step();
        guard++;
      end
      if (!acc) begin
        check("beat_accept_timeout", 0, 1);
        break;
      end
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  // Raises frame_clk and waits for commit_done. Counting the tick cycle as
  // cycle 1, the pulse is expected in cycle BINS+2, i.e. BINS+1 edges later.
  // mag_valid is left as the caller set it so back-pressure can be observed.
  task automatic commit_and_check(input string tag);
    int cyc, rdy_hi;
    cyc = 0; rdy_hi = 0;
    frame_clk = 1'b1;
    while (!done_p && cyc < BINS + 20) begin
      if (rdy_p || rdy_c) rdy_hi++;
      step();
      cyc++;
    end
    frame_clk = 1'b0;
    check({tag, "_latency"}, cyc, BINS + 1);
    check({tag, "_done_copy"}, done_c, 1);
    check({tag, "_ready_low_in_commit"}, rdy_hi, 0);
    check({tag, "_ready_after_commit"}, rdy_p, 1);
    model_commit();
    step();
    check({tag, "_done_one_cycle"}, {done_c, done_p}, 2'b00);
    compare_all(tag);
  endtask

  task automatic random_data(input int n);
    for (int i = 0; i < n; i++) beat_data[i] = $urandom;
  endtask

  // ---------------- test ----------------
  initial begin
    int pulses, rdy_hi;
    logic [WIDTH-1:0] held;

    tbl[0] = '{n_beats: 256, reset_first: 1'b0, exp_short: 1'b0, exp_over: 1'b0};
    tbl[1] = '{n_beats: 10,  reset_first: 1'b0, exp_short: 1'b1, exp_over: 1'b0};
    tbl[2] = '{n_beats: 256, reset_first: 1'b0, exp_short: 1'b1, exp_over: 1'b0};
    tbl[3] = '{n_beats: 300, reset_first: 1'b0, exp_short: 1'b1, exp_over: 1'b1};
    tbl[4] = '{n_beats: 1,   reset_first: 1'b0, exp_short: 1'b1, exp_over: 1'b1};
    tbl[5] = '{n_beats: 300, reset_first: 1'b1, exp_short: 1'b0, exp_over: 1'b1};
    tbl[6] = '{n_beats: 256, reset_first: 1'b1, exp_short: 1'b0, exp_over: 1'b0};

    step();
    do_reset();

    // Reset state
    check("reset_ready", {rdy_c, rdy_p}, 2'b11);
    check("reset_state", st_p, 0);
    check("reset_done", {done_c, done_p}, 2'b00);
    check("reset_flags", {ovr_c, ovr_p, sh_c, sh_p}, 4'b0000);
    check("reset_out_zero", (out_c == '0) && (out_p == '0), 1);

    // Basic transfer: data = index
    for (int i = 0; i < BINS; i++) beat_data[i] = WIDTH'(i);
    drive_beats(0, BINS);
    model_frame(BINS);
    commit_and_check("basic");
    check("basic_bin255", out_c[255*WIDTH +: WIDTH], 255);
    check("basic_bin17", out_c[17*WIDTH +: WIDTH], 17);

    // Peak decay: 800 -> 700 -> 613
    for (int i = 0; i < BINS; i++) beat_data[i] = '0;
    beat_data[0] = 800;
    drive_beats(0, BINS); model_frame(BINS); commit_and_check("peak_load");
    check("peak_bin0_800", out_p[WIDTH-1:0], 800);
    beat_data[0] = 0;
    drive_beats(0, BINS); model_frame(BINS); commit_and_check("peak_decay1");
    check("peak_bin0_700", out_p[WIDTH-1:0], 700);
    check("copy_bin0_0", out_c[WIDTH-1:0], 0);
    drive_beats(0, BINS); model_frame(BINS); commit_and_check("peak_decay2");
    check("peak_bin0_613", out_p[WIDTH-1:0], 613);

    // Table: random frames of varied length, flags sticky until reset
    for (int t = 0; t < 7; t++) begin
      if (tbl[t].reset_first) do_reset();
      random_data(tbl[t].n_beats);
      drive_beats(0, tbl[t].n_beats);
      model_frame(tbl[t].n_beats);
      check($sformatf("tbl%0d_short_flag", t), sh_p, tbl[t].exp_short);
      check($sformatf("tbl%0d_overrun_flag", t), ovr_p, tbl[t].exp_over);
      check($sformatf("tbl%0d_ready_waiting", t), rdy_p, 0);
      commit_and_check($sformatf("tbl%0d", t));
    end

    // Ticks during FILL are ignored
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      frame_clk = ((k % 4) < 2);
      step();
      if (done_p || done_c) pulses++;
    end
    frame_clk = 1'b0;
    check("fill_tick_no_commit", pulses, 0);
    compare_all("fill_tick");

    // Full frame then held beat while waiting; earlier ticks were not queued
    random_data(BINS);
    drive_beats(0, BINS);
    model_frame(BINS);
    random_data(BINS);
    held = beat_data[0];
    mag_valid = 1'b1; mag_data = held; mag_last = 1'b0;
    pulses = 0; rdy_hi = 0;
    for (int k = 0; k < BINS + 5; k++) begin
      if (rdy_p) rdy_hi++;
      if (done_p) pulses++;
      step();
    end
    check("wait_no_queued_tick", pulses, 0);
    check("wait_ready_low", rdy_hi, 0);
    commit_and_check("backpressure");
    // The held beat was taken on the first FILL cycle; send the rest.
    drive_beats(1, BINS);
    model_frame(BINS);
    commit_and_check("held_frame");
    check("held_beat_bin0", out_c[WIDTH-1:0], held);

    // Reset at commit cycle 100
    random_data(BINS);
    drive_beats(0, BINS);
    model_frame(BINS);
    frame_clk = 1'b1;
    step();
    for (int k = 0; k < 100; k++) step();
    check("midcommit_in_commit", rdy_p, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    frame_clk = 1'b0;
    for (int i = 0; i < BINS; i++) begin m_copy[i] = '0; m_peak[i] = '0; end
    m_short = 1'b0; m_over = 1'b0;
    check("midcommit_out_zero", (out_c == '0) && (out_p == '0), 1);
    check("midcommit_ready", rdy_p, 1);
    check("midcommit_state", st_p, 0);
    pulses = 0;
    for (int k = 0; k < BINS + 5; k++) begin
      if (done_p || done_c) pulses++;
      step();
    end
    check("midcommit_no_done", pulses, 0);
    compare_all("midcommit");

    // Recovery frame after the aborted commit
    random_data(BINS);
    drive_beats(0, BINS);
    model_frame(BINS);
    commit_and_check("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spectrum_capture.md
SPECTRUM_CAPTURE -- requirements
Module: spectrum_capture

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BINS, 256, magnitude bins per frame.
- WIDTH, 32, bits per bin.
- DECAY_SHIFT, 3, peak-hold decay shift.
- PEAK_HOLD, 1, 1 = peak-hold with decay, 0 = plain copy.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- Clk, in, 1, sole clock; all logic rises on posedge Clk.
- Reset, in, 1, synchronous, active-high.
- frame_clk, in, 1, video frame tick, level signal, sampled on Clk.
- mag_data, in, WIDTH, FFT magnitude for the current bin.
- mag_valid, in, 1, mag_data is valid.
- mag_last, in, 1, marks the final beat of an FFT frame.
- mag_ready, out, 1, block accepts a beat.
- audio_output, out, BINS*WIDTH, display spectrum; bin i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH], feeding the bar generator.
- commit_done, out, 1, one-cycle pulse when a commit finishes.
- overrun, out, 1, sticky flag: a frame exceeded BINS beats.
- short_frame, out, 1, sticky flag: mag_last arrived before BINS beats.

Function
REQ-003 Storage: internal shadow buffer of BINS x WIDTH words, separate from the audio_output register.
REQ-004 State machine has four states: FILL, DRAIN, WAIT_TICK, COMMIT.
REQ-005 mag_ready = 1 in FILL and DRAIN; mag_ready = 0 in WAIT_TICK and COMMIT.
REQ-006 A beat transfers only in the cycle where mag_valid && mag_ready; with mag_valid low, state and counters hold.
REQ-007 FILL, on each accepted beat: shadow[wr_idx] <= mag_data, then wr_idx increments. wr_idx is log2(BINS) bits wide.
REQ-008 FILL, beat with mag_last=1 and wr_idx==BINS-1: go to WAIT_TICK; wr_idx <= 0.
REQ-009 FILL, beat with mag_last=1 and wr_idx<BINS-1:
- set short_frame;
- go to WAIT_TICK; wr_idx <= 0;
- unwritten shadow bins keep their previous contents.
REQ-010 FILL, beat with mag_last=0 and wr_idx==BINS-1: store the beat, set overrun, go to DRAIN.
REQ-011 DRAIN: accepted beats are discarded; a beat with mag_last=1 moves to WAIT_TICK.
REQ-012 Tick detection: frame_clk is registered once; tick = frame_clk && !frame_clk_q, a rising edge in the Clk domain.
REQ-013 A tick is acted on only in WAIT_TICK and moves to COMMIT with rd_idx <= 0. Ticks in any other state are ignored and not queued.
REQ-014 COMMIT processes one bin per cycle, i = rd_idx:
- PEAK_HOLD=0: out[i] <= shadow[i].
- PEAK_HOLD=1: out[i] <= max(shadow[i], out[i] - (out[i] >> DECAY_SHIFT)).
- All arithmetic is unsigned WIDTH-bit; the subtraction cannot underflow.
REQ-015 COMMIT lasts exactly BINS cycles. After bin BINS-1:
- commit_done pulses high for exactly one cycle;
- next state is FILL.
REQ-016 Bins not being written in a COMMIT cycle hold their value. audio_output changes only during COMMIT.
REQ-017 Latency from tick rising edge to commit_done: 1 cycle edge register, +1 cycle state transition, +BINS cycles commit.
REQ-018 mag_valid during WAIT_TICK or COMMIT is back-pressured; no data is lost and no flag is set.
REQ-019 overrun and short_frame remain set until Reset.

Reset
REQ-020 When Reset=1 at a Clk edge, all of the following take effect in that cycle, including mid-FILL and mid-COMMIT:
- state <= FILL; wr_idx, rd_idx <= 0;
- audio_output <= 0; commit_done, overrun, short_frame <= 0; frame_clk_q <= 0.
REQ-021 Shadow contents are unspecified after reset. The first full frame defines all BINS bins.
REQ-022 The first cycle after Reset deasserts has mag_ready = 1.

Verification
REQ-023 Basic transfer, PEAK_HOLD=0:
- stimulus: stream 256 beats with data = index, mag_last on beat 255, then pulse frame_clk;
- response: after 258 cycles, commit_done pulses; bin i = i; flags = 0.
REQ-024 Peak decay, PEAK_HOLD=1, DECAY_SHIFT=3:
- stimulus: commit frame with bin0 = 800, then commit an all-zero frame;
- response: bin0 = 700, then 613 after the next zero frame.
REQ-025 Short frame:
- stimulus: mag_last on beat 9;
- response: short_frame = 1; WAIT_TICK entered; bins 10..255 of the next commit equal the prior shadow values.
REQ-026 Overrun:
- stimulus: 300 beats, mag_last on beat 299;
- response: overrun = 1; beats 256..299 dropped; commit shows beats 0..255.
REQ-027 Backpressure and ignored ticks:
- stimulus: frame_clk edges during FILL; mag_valid held high through WAIT_TICK/COMMIT;
- response: no commit occurs; mag_ready = 0 for the whole of WAIT_TICK/COMMIT; the held beat is accepted on the first FILL cycle.
REQ-028 Reset mid-commit:
- stimulus: assert Reset at commit cycle 100;
- response: audio_output = 0 next cycle; no commit_done; state FILL; mag_ready = 1.
